stage_ex_alu: RTL
=================

// Module: stage_ex_alu
// PURPOSE
//  Execute stage of the 5-stage RV32IM turbo pipeline, directly downstream of instruction decode.
//  Consumes the decoded bundle {PC, RR1, RR2, RAR, DCR, Imm} and computes ALU, shift, link and LUI/AUIPC results.
//  Resolves conditional branches and runs an iterative multiplier for MUL.
//  Registers results into ASR, which feeds the memory-access stage and is forwarded back to decode as ASR_of_EX.
// PARAMETERS
//  MUL_BITS  2  multiplier bits retired per iteration; legal values 1, 2, 4; iterations N = 32/MUL_BITS
// PORTS
//  clk               in   1   clock
//  rst               in   1   synchronous, active-high reset
//  Done_I            in   1   decode bundle valid this cycle
//  PC_I              in   32  instruction PC
//  RR1_I, RR2_I      in   32  forwarded register operands
//  RAR_I             in   5   destination register (0 = no write)
//  DCR_I             in   20  {auipc, f3[2:0], R, I_CS, I_L, I_J, S, U, B, J, MUL, I, SFT, ALUop[2:0], SFTop[1:0]}
//  Imm_I             in   32  sign-extended immediate
//  Feedback_Mem_Acc  in   1   memory stage stall; freezes every register in this block
//  Done_O            out  1   result bundle valid
//  PC_O              out  32  registered PC_I
//  ASR               out  32  ALU/shift/link/MUL result register; also the EX forwarding source
//  RAR_O             out  5   registered destination register
//  MA_Ctrl           out  5   {I_L, S, f3[2:0]} for the memory-access stage
//  Store_Data        out  32  registered RR2_I
//  Feedback_Branch   out  1   taken-branch flush request (combinational)
//  Branch_Target     out  32  {(PC_I+Imm_I)[31:2], 2'b00}
//  Busy_O            out  1   multiplier occupied; upstream holds its bundle while high
// BEHAVIOUR
//  Reset values: Done_O, Busy_O, ASR, PC_O, RAR_O, MA_Ctrl, Store_Data = 0; FSM = IDLE.
//  Operand A: PC_I if auipc|J|I_J; 0 if U & !auipc; RR1_I otherwise.
//  Operand B: 4 if J|I_J; RR2_I if R|B; Imm_I otherwise.
//  ALUop: 000 add, 001 sub, 010 slt, 011 sltu, 100 xor, 110 or, 111 and (101 unused; yields 0).
//  Shifts (SFT=1) take the shifter result instead of the ALU; shift amount = B[4:0].
//  SFTop: 00 sll, 10 srl, 11 sra.
//  All arithmetic is mod 2^32. slt is signed; sltu is unsigned.
//  Branches use the ALU result, then XOR the decision with f3[0]:
//   - f3[2]=0: taken = (A-B == 0).
//   - f3[2]=1: taken = result[0].
//  Feedback_Branch = Done_I & B & taken & !Feedback_Mem_Acc & (state==IDLE). It is high for exactly one cycle.
//  Jumps never assert Feedback_Branch; decode redirects them. A branch writes no register: RAR_O <= 0.
//  Non-MUL latency: 1 cycle. If Done_I & !Feedback_Mem_Acc in IDLE, all outputs load next edge and Done_O <= 1.
//   Otherwise Done_O <= 0, unless stalled.
//  FSM: IDLE -> MULT -> IDLE.
//   - IDLE: on Done_I & MUL & !Feedback_Mem_Acc, latch multiplicand RR1_I and multiplier RR2_I, clear product,
//     cnt <= N-1, Busy_O <= 1, Done_O <= 0.
//   - MULT: each unstalled cycle, product += multiplicand * multiplier[MUL_BITS-1:0].
//     Then multiplicand <<= MUL_BITS, multiplier >>= MUL_BITS, cnt--.
//   - MULT, on the cycle with cnt == 0: ASR <= low 32 bits of final product, Done_O <= 1, Busy_O <= 0,
//     RAR_O/PC_O <= latched values, go to IDLE.
//   - MUL latency: N+1 edges from acceptance to Done_O (N=16 by default).
//  Done_I is ignored in MULT; the upstream bundle is consumed only in IDLE.
//  Feedback_Mem_Acc high: every register holds (FSM state, cnt, product, Done_O, ASR).
//   Feedback_Branch is forced low.
//  Simultaneous stall and MUL acceptance: the stall wins, and acceptance retries next cycle.
//  rst mid-MULT: FSM returns to IDLE, the partial product is discarded, Done_O = Busy_O = 0 next cycle.
//  x0 writes are not special-cased: RAR_O = 0 passes through; ASR is still computed.
// TESTING
//  1. add: RR1=5, RR2=0xFFFFFFFD, R, ALUop 000 -> next cycle ASR=2, Done_O=1, RAR_O=RAR_I.
//  2. blt: RR1=-1, RR2=1, f3=100, PC=0x100, Imm=0x20 -> same cycle Feedback_Branch=1, Branch_Target=0x120.
//     Next cycle RAR_O=0.
//  3. sra: RR1=0x80000000, Imm=4, SFTop 11 -> ASR=0xF8000000. srl of the same value -> 0x08000000.
//  4. MUL 7 * 0xFFFFFFFD -> Busy_O high for 16 cycles, then ASR=0xFFFFFFEB and Done_O=1 on edge 17.
//  5. Feedback_Mem_Acc held 3 cycles during MULT -> completion delayed exactly 3 cycles, result unchanged.
//  6. rst at iteration 5 of a MUL -> IDLE, Done_O=0, Busy_O=0. A following add completes normally in 1 cycle.

Source files
------------

// File: rtl/stage_ex_alu.sv
// Execute stage: ALU, shifter, branch resolution and iterative multiplier for the RV32IM pipeline.
// Results are registered into ASR and forwarded to memory access and back to decode.
module stage_ex_alu #(
    parameter int MUL_BITS = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Done_I,
    input  logic [31:0] PC_I,
    input  logic [31:0] RR1_I,
    input  logic [31:0] RR2_I,
    input  logic [4:0]  RAR_I,
    input  logic [19:0] DCR_I,
    input  logic [31:0] Imm_I,
    input  logic        Feedback_Mem_Acc,
    output logic        Done_O,
    output logic [31:0] PC_O,
    output logic [31:0] ASR,
    output logic [4:0]  RAR_O,
    output logic [4:0]  MA_Ctrl,
    output logic [31:0] Store_Data,
    output logic        Feedback_Branch,
    output logic [31:0] Branch_Target,
    output logic        Busy_O
);
    localparam int         N        = 32 / MUL_BITS;
    localparam logic [4:0] CNT_LAST = 5'(N - 1);
    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_MULT   = 1'b1;

    logic        w_auipc, w_r, w_il, w_ij, w_s, w_u, w_b, w_j, w_mul, w_sft;
    logic [2:0]  w_f3, w_aluop;
    logic [1:0]  w_sftop;
    logic [31:0] w_op_a, w_op_b, w_sum, w_diff, w_alu, w_shift, w_res, w_tgt;
    logic signed [31:0] w_op_a_s, w_op_b_s;
    logic        w_taken, w_accept, w_unused;
    logic [31:0] w_mul_step, w_prod_next;

    logic [0:0]  r_state;
    logic [4:0]  r_cnt;
    logic [31:0] r_mcand, r_mplier, r_prod, r_mul_pc;
    logic [4:0]  r_mul_rar, r_mul_ma;

    assign w_auipc = DCR_I[19];
    assign w_f3    = DCR_I[18:16];
    assign w_r     = DCR_I[15];
    assign w_il    = DCR_I[13];
    assign w_ij    = DCR_I[12];
    assign w_s     = DCR_I[11];
    assign w_u     = DCR_I[10];
    assign w_b     = DCR_I[9];
    assign w_j     = DCR_I[8];
    assign w_mul   = DCR_I[7];
    assign w_sft   = DCR_I[5];
    assign w_aluop = DCR_I[4:2];
    assign w_sftop = DCR_I[1:0];

    assign w_op_a = (w_auipc | w_j | w_ij) ? PC_I :
                    w_u                    ? 32'd0 : RR1_I;
    assign w_op_b = (w_j | w_ij) ? 32'd4 :
                    (w_r | w_b)  ? RR2_I : Imm_I;
    assign w_op_a_s = w_op_a;
    assign w_op_b_s = w_op_b;
    assign w_sum    = w_op_a + w_op_b;
    assign w_diff   = w_op_a - w_op_b;

    always_comb begin
        w_alu = 32'd0;
        case (w_aluop)
            3'b000:  w_alu = w_sum;
            3'b001:  w_alu = w_diff;
            3'b010:  w_alu = {31'd0, w_op_a_s < w_op_b_s};
            3'b011:  w_alu = {31'd0, w_op_a < w_op_b};
            3'b100:  w_alu = w_op_a ^ w_op_b;
            3'b110:  w_alu = w_op_a | w_op_b;
            3'b111:  w_alu = w_op_a & w_op_b;
            default: w_alu = 32'd0;
        endcase
    end

    always_comb begin
        w_shift = 32'd0;
        case (w_sftop)
            2'b00:   w_shift = w_op_a << w_op_b[4:0];
            2'b10:   w_shift = w_op_a >> w_op_b[4:0];
            2'b11:   w_shift = 32'(w_op_a_s >>> w_op_b[4:0]);
            default: w_shift = 32'd0;
        endcase
    end

    assign w_res = w_sft ? w_shift : w_alu;

    // beq/bne compare by equality; the ordered compares reuse the slt/sltu bit
    assign w_taken  = (w_f3[2] ? w_alu[0] : (w_diff == 32'd0)) ^ w_f3[0];
    assign w_accept = Done_I & ~Feedback_Mem_Acc & (r_state == S_IDLE);
    assign Feedback_Branch = w_accept & w_b & w_taken;
    assign w_tgt         = PC_I + Imm_I;
    assign Branch_Target = {w_tgt[31:2], 2'b00};

    assign w_mul_step  = r_mcand * {{(32 - MUL_BITS){1'b0}}, r_mplier[MUL_BITS-1:0]};
    assign w_prod_next = r_prod + w_mul_step;

    assign w_unused = &{1'b0, DCR_I[14], DCR_I[6], w_tgt[1:0]};

    // Control and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 5'd0;
            Done_O     <= 1'b0;
            Busy_O     <= 1'b0;
            ASR        <= 32'd0;
            PC_O       <= 32'd0;
            RAR_O      <= 5'd0;
            MA_Ctrl    <= 5'd0;
            Store_Data <= 32'd0;
        end else if (!Feedback_Mem_Acc) begin
            case (r_state)
                S_IDLE: begin
                    if (Done_I && w_mul) begin
                        r_state <= S_MULT;
                        r_cnt   <= CNT_LAST;
                        Busy_O  <= 1'b1;
                        Done_O  <= 1'b0;
                    end else if (Done_I) begin
                        Done_O     <= 1'b1;
                        ASR        <= w_res;
                        PC_O       <= PC_I;
                        RAR_O      <= w_b ? 5'd0 : RAR_I;
                        MA_Ctrl    <= {w_il, w_s, w_f3};
                        Store_Data <= RR2_I;
                    end else begin
                        Done_O <= 1'b0;
                    end
                end
                default: begin
                    if (r_cnt == 5'd0) begin
                        r_state <= S_IDLE;
                        ASR     <= w_prod_next;
                        Done_O  <= 1'b1;
                        Busy_O  <= 1'b0;
                        RAR_O   <= r_mul_rar;
                        PC_O    <= r_mul_pc;
                        MA_Ctrl <= r_mul_ma;
                    end else begin
                        r_cnt <= r_cnt - 5'd1;
                    end
                end
            endcase
        end
    end

    // Multiplier datapath
    always_ff @(posedge clk) begin
        if (!Feedback_Mem_Acc) begin
            if (r_state == S_IDLE && Done_I && w_mul) begin
                r_mcand   <= RR1_I;
                r_mplier  <= RR2_I;
                r_prod    <= 32'd0;
                r_mul_rar <= RAR_I;
                r_mul_pc  <= PC_I;
                r_mul_ma  <= {w_il, w_s, w_f3};
            end else if (r_state == S_MULT) begin
                r_prod   <= w_prod_next;
                r_mcand  <= r_mcand << MUL_BITS;
                r_mplier <= r_mplier >> MUL_BITS;
            end
        end
    end
endmodule
